// File: rtl/instr_reg_sched_pkg.sv
// Types and constants shared by the instruction-register scheduler, its arbiter and its bus interface.
// Latency: none (declarations only).
// Backpressure: n/a.
package instr_register_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_LOAD  = 4'd6,
    OP_STORE = 4'd7
  } opcode_t;

  typedef logic [15:0] operand_t;
  typedef logic [4:0]  address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  // Ring depth is tied to the address width so pointers wrap for free.
  localparam int DEPTH = 2 ** $bits(address_t);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} sched_state_t;

endpackage

// File: rtl/instr_reg_sched_if.sv
// Bus bundle between producers/consumer and the scheduler (slave = scheduler side).
// Latency: none (wiring only).
// Backpressure: reqN_ready qualifies reqN_valid; the read side has no backpressure.
// Optional stats counters appear when INSTR_SCHED_STATS_EN is defined.
interface instr_reg_sched_if;
  import instr_register_pkg::*;

  logic     req0_valid, req1_valid;
  opcode_t  req0_opcode, req1_opcode;
  operand_t req0_operand_a, req0_operand_b;
  operand_t req1_operand_a, req1_operand_b;
  logic     req0_ready, req1_ready;
  logic     rd_start;
  count_t   rd_len;
  logic     load_en;
  opcode_t  opcode;
  operand_t operand_a, operand_b;
  address_t write_pointer, read_pointer;
  logic     rd_valid, rd_done;
  count_t   count;
  logic     full, empty;
`ifdef INSTR_SCHED_STATS_EN
  logic [15:0] grant0_cnt, grant1_cnt, stall_cnt;
`endif

  modport master (
    output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
           req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
           rd_start, rd_len,
    input  req0_ready, req1_ready, load_en, opcode, operand_a, operand_b,
           write_pointer, read_pointer, rd_valid, rd_done, count, full, empty
`ifdef INSTR_SCHED_STATS_EN
    , input grant0_cnt, grant1_cnt, stall_cnt
`endif
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
           req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
           rd_start, rd_len,
    output req0_ready, req1_ready, load_en, opcode, operand_a, operand_b,
           write_pointer, read_pointer, rd_valid, rd_done, count, full, empty
`ifdef INSTR_SCHED_STATS_EN
    , output grant0_cnt, grant1_cnt, stall_cnt
`endif
  );

endinterface

// File: rtl/instr_reg_sched_rr_arb2.sv
// Two-requester round-robin arbiter; grants are combinational from req and the last winner.
// Latency: 0 cycles (grant same cycle as request).
// Backpressure: hold forces both grants low and freezes the last-winner state.
// Ports: clk, reset (sync, active-high), req0/req1 in, hold in, gnt0/gnt1 out.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic hold,
  output logic gnt0,
  output logic gnt1
);

  // 1 = requester 1 won most recently; reset value makes requester 0 win the first tie.
  logic last_grant;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!hold) begin
      if (req0 && req1) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_reg_sched.sv
// Write/read scheduler for the DEPTH-entry instruction register ring: RR write arbitration plus drain FSM.
// Latency: transfer -> load_en next cycle; read_pointer presented -> rd_valid next cycle.
// Backpressure: both reqN_ready drop while full; drain stalls in DRAIN while empty.
// Ports: clk, reset (sync, active-high), bus (instr_reg_sched_if.slave: producer handshakes,
// write payload/pointer, read pointer/valid/done, occupancy). Macro INSTR_SCHED_STATS_EN adds
// saturating grant0_cnt/grant1_cnt/stall_cnt.
module instr_reg_sched
  import instr_register_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  instr_reg_sched_if.slave  bus
);

  logic         gnt0, gnt1, wr_xfer, rd_issue, full_w;
  logic         load_q, rd_valid_q, rd_done_q, drain_all;
  opcode_t      opc_q;
  operand_t     a_q, b_q;
  address_t     wp_q, rp_q;
  count_t       count_q, remaining;
  sched_state_t state;

  assign full_w = (count_q == CNT_W'(DEPTH));

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (bus.req0_valid),
    .req1  (bus.req1_valid),
    .hold  (full_w),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign wr_xfer  = gnt0 | gnt1;
  // Uses the registered count, so an entry transferred this cycle is never read in the same cycle.
  assign rd_issue = (state == DRAIN) && (count_q != '0);

  assign bus.req0_ready    = gnt0;
  assign bus.req1_ready    = gnt1;
  assign bus.load_en       = load_q;
  assign bus.opcode        = opc_q;
  assign bus.operand_a     = a_q;
  assign bus.operand_b     = b_q;
  assign bus.write_pointer = wp_q;
  assign bus.read_pointer  = rp_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_done       = rd_done_q;
  assign bus.count         = count_q;
  assign bus.full          = full_w;
  assign bus.empty         = (count_q == '0);

  // Write side: write_pointer names the slot being loaded and advances after each load strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q <= 1'b0;
      opc_q  <= OP_NOP;
      a_q    <= '0;
      b_q    <= '0;
      wp_q   <= '0;
    end else begin
      load_q <= wr_xfer;
      if (load_q) wp_q <= wp_q + address_t'(1);
      if (wr_xfer) begin
        if (gnt0) begin
          opc_q <= bus.req0_opcode;
          a_q   <= bus.req0_operand_a;
          b_q   <= bus.req0_operand_b;
        end else begin
          opc_q <= bus.req1_opcode;
          a_q   <= bus.req1_operand_a;
          b_q   <= bus.req1_operand_b;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(wr_xfer) - CNT_W'(rd_issue);
    end
  end

  // Drain FSM with registered rd_valid/rd_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      drain_all  <= 1'b0;
      rp_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue;
      rd_done_q  <= 1'b0;
      if (rd_issue) rp_q <= rp_q + address_t'(1);
      case (state)
        IDLE: begin
          if (bus.rd_start) begin
            state     <= DRAIN;
            remaining <= bus.rd_len;
            drain_all <= (bus.rd_len == '0);
          end
        end
        DRAIN: begin
          if (drain_all) begin
            // Drain-all finishes on the first DRAIN cycle that sees an empty ring.
            if (count_q == '0) begin
              state     <= DONE;
              rd_done_q <= 1'b1;
            end
          end else if (rd_issue) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state     <= DONE;
              rd_done_q <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INSTR_SCHED_STATS_EN
  logic [15:0] g0_cnt, g1_cnt, st_cnt;

  assign bus.grant0_cnt = g0_cnt;
  assign bus.grant1_cnt = g1_cnt;
  assign bus.stall_cnt  = st_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      g0_cnt <= '0;
      g1_cnt <= '0;
      st_cnt <= '0;
    end else begin
      if (gnt0 && (g0_cnt != 16'hFFFF)) g0_cnt <= g0_cnt + 16'd1;
      if (gnt1 && (g1_cnt != 16'hFFFF)) g1_cnt <= g1_cnt + 16'd1;
      if ((bus.req0_valid || bus.req1_valid) && full_w && (st_cnt != 16'hFFFF))
        st_cnt <= st_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_reg_sched.sv
`timescale 1ns/1ps
module tb_instr_reg_sched;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_reg_sched_if bus ();

  instr_reg_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req0_valid     = 1'b0;
    bus.req1_valid     = 1'b0;
    bus.req0_opcode    = OP_NOP;
    bus.req1_opcode    = OP_NOP;
    bus.req0_operand_a = '0;
    bus.req0_operand_b = '0;
    bus.req1_operand_a = '0;
    bus.req1_operand_b = '0;
    bus.rd_start       = 1'b0;
    bus.rd_len         = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: one row per cycle, sampled at the falling edge.
  typedef struct {
    bit       pre_rst;
    bit       v0, v1;
    operand_t a0;
    bit       r0, r1, ld;
    address_t wp;
    count_t   cnt;
    opcode_t  op;
    operand_t ea;
  } vec_t;

  function automatic vec_t mk(bit pr, bit v0, bit v1, int a0, bit r0, bit r1, bit ld,
                              int wp, int cnt, opcode_t op, int ea);
    vec_t v;
    v.pre_rst = pr; v.v0 = v0; v.v1 = v1; v.a0 = operand_t'(a0);
    v.r0 = r0; v.r1 = r1; v.ld = ld;
    v.wp = address_t'(wp); v.cnt = count_t'(cnt); v.op = op; v.ea = operand_t'(ea);
    return v;
  endfunction

  vec_t vecs[10];

  // Reference model: ring content as a queue of {word, slot}, drain as a few flags/counters.
  typedef struct {
    instruction_t w;
    address_t     addr;
  } ent_t;

  ent_t         st_q[$];
  int           m_last, m_wr_total, m_rem, occ;
  bit           m_pend_v, m_rv, m_done, m_drain, m_all, done_now;
  instruction_t m_pend_w, w0, w1;
  address_t     m_pend_a;
  bit           g0, g1, iss, st;
  count_t       len;

  // Scratch for directed sequences.
  int       n, rv_n, done_n, first_rv, last_rv, done_c;
  address_t prev_rp;
  address_t ptrs[$];

  initial begin
    drive_idle();

    // ---------------- reset state ----------------
    do_reset();
    @(negedge clk);
    chk("rst load_en", 32'(bus.load_en), 32'(0));
    chk("rst write_pointer", 32'(bus.write_pointer), 32'(0));
    chk("rst read_pointer", 32'(bus.read_pointer), 32'(0));
    chk("rst count", 32'(bus.count), 32'(0));
    chk("rst empty", 32'(bus.empty), 32'(1));
    chk("rst full", 32'(bus.full), 32'(0));
    chk("rst rd_valid", 32'(bus.rd_valid), 32'(0));
    chk("rst rd_done", 32'(bus.rd_done), 32'(0));
    chk("rst opcode", 32'(bus.opcode), 32'(0));
    chk("rst operand_a", 32'(bus.operand_a), 32'(0));
    next_cycle();

    // ---------------- table: first write and alternating grants ----------------
    vecs[0] = mk(1, 0, 0,  0, 0, 0, 0, 0, 0, OP_NOP,   0);
    vecs[1] = mk(0, 1, 0,  5, 1, 0, 0, 0, 0, OP_NOP,   0);
    vecs[2] = mk(0, 0, 0,  0, 0, 0, 1, 0, 1, OP_ADD,   5);
    vecs[3] = mk(0, 0, 0,  0, 0, 0, 0, 1, 1, OP_NOP,   0);
    vecs[4] = mk(1, 1, 1, 10, 1, 0, 0, 0, 0, OP_NOP,   0);
    vecs[5] = mk(0, 1, 1, 11, 0, 1, 1, 0, 1, OP_ADD,  10);
    vecs[6] = mk(0, 1, 1, 12, 1, 0, 1, 1, 2, OP_SUB, 111);
    vecs[7] = mk(0, 1, 1, 13, 0, 1, 1, 2, 3, OP_ADD,  12);
    vecs[8] = mk(0, 0, 0,  0, 0, 0, 1, 3, 4, OP_SUB, 113);
    vecs[9] = mk(0, 0, 0,  0, 0, 0, 0, 4, 4, OP_NOP,   0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_rst) do_reset();
      bus.req0_valid     = vecs[i].v0;
      bus.req0_opcode    = OP_ADD;
      bus.req0_operand_a = vecs[i].a0;
      bus.req0_operand_b = 16'd3;
      bus.req1_valid     = vecs[i].v1;
      bus.req1_opcode    = OP_SUB;
      bus.req1_operand_a = vecs[i].a0 + 16'd100;
      bus.req1_operand_b = 16'd3;
      @(negedge clk);
      chk($sformatf("vec%0d req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
      chk($sformatf("vec%0d req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
      chk($sformatf("vec%0d load_en", i), 32'(bus.load_en), 32'(vecs[i].ld));
      chk($sformatf("vec%0d write_pointer", i), 32'(bus.write_pointer), 32'(vecs[i].wp));
      chk($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(vecs[i].cnt == 0));
      if (vecs[i].ld) begin
        chk($sformatf("vec%0d opcode", i), 32'(bus.opcode), 32'(vecs[i].op));
        chk($sformatf("vec%0d operand_a", i), 32'(bus.operand_a), 32'(vecs[i].ea));
        chk($sformatf("vec%0d operand_b", i), 32'(bus.operand_b), 32'(3));
      end
      next_cycle();
    end

    // ---------------- fill to full, stall, 1-entry drain, wrap to slot 0 ----------------
    do_reset();
    bus.req0_valid  = 1'b1;
    bus.req0_opcode = OP_ADD;
    n = 0;
    for (int c = 0; c < 100 && n < DEPTH; c++) begin
      @(negedge clk);
      if (bus.req0_ready) n++;
      next_cycle();
      bus.req0_operand_a = operand_t'(n);
    end
    chk("fill transfers", 32'(n), 32'(DEPTH));
    bus.req1_valid     = 1'b1;
    bus.req1_opcode    = OP_XOR;
    bus.req1_operand_a = 16'hBEEF;
    @(negedge clk);
    chk("full flag", 32'(bus.full), 32'(1));
    chk("full count", 32'(bus.count), 32'(DEPTH));
    chk("full ready0", 32'(bus.req0_ready), 32'(0));
    chk("full ready1", 32'(bus.req1_ready), 32'(0));
    next_cycle();
    bus.rd_start = 1'b1;
    bus.rd_len   = count_t'(1);
    @(negedge clk);
    chk("stall ready0", 32'(bus.req0_ready), 32'(0));
    chk("stall ready1", 32'(bus.req1_ready), 32'(0));
    next_cycle();
    bus.rd_start = 1'b0;
    @(negedge clk);
    chk("drain1 read_pointer", 32'(bus.read_pointer), 32'(0));
    chk("drain1 ready1 still low", 32'(bus.req1_ready), 32'(0));
    next_cycle();
    @(negedge clk);
    chk("freed ready1", 32'(bus.req1_ready), 32'(1));
    chk("freed ready0", 32'(bus.req0_ready), 32'(0));
    chk("drain1 rd_valid", 32'(bus.rd_valid), 32'(1));
    chk("drain1 rd_done", 32'(bus.rd_done), 32'(1));
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("wrap load_en", 32'(bus.load_en), 32'(1));
    chk("wrap write_pointer", 32'(bus.write_pointer), 32'(0));
    chk("wrap operand_a", 32'(bus.operand_a), 32'(16'hBEEF));
    chk("wrap count", 32'(bus.count), 32'(DEPTH));
    next_cycle();

    // ---------------- drain-all of 3 entries ----------------
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.req0_valid     = 1'b1;
      bus.req0_opcode    = OP_LOAD;
      bus.req0_operand_a = operand_t'(k + 1);
      next_cycle();
    end
    drive_idle();
    repeat (2) next_cycle();
    bus.rd_start = 1'b1;
    bus.rd_len   = '0;
    @(negedge clk);
    prev_rp = bus.read_pointer;
    next_cycle();
    bus.rd_start = 1'b0;
    rv_n = 0; done_n = 0; first_rv = -1; last_rv = -1; done_c = -1;
    ptrs.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        rv_n++;
        ptrs.push_back(prev_rp);
        if (first_rv < 0) first_rv = c;
        last_rv = c;
      end
      if (bus.rd_done) begin
        done_n++;
        done_c = c;
      end
      prev_rp = bus.read_pointer;
      next_cycle();
    end
    chk("drainall rd_valid cycles", 32'(rv_n), 32'(3));
    chk("drainall first rd_valid", 32'(first_rv), 32'(1));
    chk("drainall contiguous", 32'(last_rv - first_rv), 32'(2));
    for (int k = 0; k < ptrs.size() && k < 3; k++)
      chk($sformatf("drainall ptr%0d", k), 32'(ptrs[k]), 32'(k));
    chk("drainall rd_done pulses", 32'(done_n), 32'(1));
    chk("drainall rd_done timing", 32'(done_c), 32'(last_rv + 1));
    chk("drainall empty", 32'(bus.empty), 32'(1));

    // ---------------- drain of 2 started on an empty ring ----------------
    do_reset();
    bus.rd_start = 1'b1;
    bus.rd_len   = count_t'(2);
    next_cycle();
    bus.rd_start = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rd_valid || bus.rd_done) n++;
      next_cycle();
    end
    chk("empty-stall no read", 32'(n), 32'(0));
    for (int w = 0; w < 2; w++) begin
      bus.req0_valid     = 1'b1;
      bus.req0_opcode    = OP_STORE;
      bus.req0_operand_a = operand_t'(w + 40);
      @(negedge clk);
      chk($sformatf("stall w%0d ready0", w), 32'(bus.req0_ready), 32'(1));
      next_cycle();
      drive_idle();
      @(negedge clk);
      chk($sformatf("stall w%0d rd_valid early", w), 32'(bus.rd_valid), 32'(0));
      chk($sformatf("stall w%0d read_pointer", w), 32'(bus.read_pointer), 32'(w));
      next_cycle();
      @(negedge clk);
      chk($sformatf("stall w%0d rd_valid", w), 32'(bus.rd_valid), 32'(1));
      chk($sformatf("stall w%0d rd_done", w), 32'(bus.rd_done), 32'(w == 1));
      next_cycle();
      repeat (2) next_cycle();
    end

    // ---------------- reset during a 5-entry drain ----------------
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.req0_valid     = 1'b1;
      bus.req0_opcode    = OP_ADD;
      bus.req0_operand_a = operand_t'(16'h55 + k);
      next_cycle();
    end
    drive_idle();
    next_cycle();
    bus.rd_start = 1'b1;
    bus.rd_len   = count_t'(5);
    next_cycle();
    bus.rd_start = 1'b0;
    repeat (3) next_cycle();
    // Three reads issued, two remaining; a write offer in the same cycle must be dropped.
    reset              = 1'b1;
    bus.req0_valid     = 1'b1;
    bus.req0_operand_a = 16'h1234;
    @(negedge clk);
    chk("midrst read_pointer before", 32'(bus.read_pointer), 32'(3));
    next_cycle();
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    chk("midrst load_en", 32'(bus.load_en), 32'(0));
    chk("midrst count", 32'(bus.count), 32'(0));
    chk("midrst empty", 32'(bus.empty), 32'(1));
    chk("midrst full", 32'(bus.full), 32'(0));
    chk("midrst rd_valid", 32'(bus.rd_valid), 32'(0));
    chk("midrst rd_done", 32'(bus.rd_done), 32'(0));
    chk("midrst read_pointer", 32'(bus.read_pointer), 32'(0));
    chk("midrst write_pointer", 32'(bus.write_pointer), 32'(0));
    chk("midrst operand_a", 32'(bus.operand_a), 32'(0));
    next_cycle();
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rd_done || bus.rd_valid || bus.load_en) n++;
      next_cycle();
    end
    chk("midrst no late activity", 32'(n), 32'(0));

    // ---------------- randomized traffic against the reference model ----------------
    do_reset();
    st_q.delete();
    m_last = 1; m_wr_total = 0; m_rem = 0;
    m_pend_v = 0; m_rv = 0; m_done = 0; m_drain = 0; m_all = 0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      if ((cyc % 400) < 200) begin
        bus.req0_valid = ($urandom_range(0, 99) < 75);
        bus.req1_valid = ($urandom_range(0, 99) < 75);
        bus.rd_start   = ($urandom_range(0, 19) == 0);
      end else begin
        bus.req0_valid = ($urandom_range(0, 99) < 20);
        bus.req1_valid = ($urandom_range(0, 99) < 20);
        bus.rd_start   = ($urandom_range(0, 3) == 0);
      end
      bus.rd_len         = count_t'($urandom_range(0, 8));
      bus.req0_opcode    = opcode_t'($urandom_range(0, 7));
      bus.req1_opcode    = opcode_t'($urandom_range(0, 7));
      bus.req0_operand_a = operand_t'($urandom);
      bus.req0_operand_b = operand_t'($urandom);
      bus.req1_operand_a = operand_t'($urandom);
      bus.req1_operand_b = operand_t'($urandom);

      @(negedge clk);
      w0  = '{opc: bus.req0_opcode, op_a: bus.req0_operand_a, op_b: bus.req0_operand_b};
      w1  = '{opc: bus.req1_opcode, op_a: bus.req1_operand_a, op_b: bus.req1_operand_b};
      st  = bus.rd_start;
      len = bus.rd_len;
      occ = st_q.size();
      // Sole requester wins; on a tie, the one that did not win most recently wins; nobody while full.
      g0 = 0; g1 = 0;
      if (occ < DEPTH) begin
        if (bus.req0_valid && bus.req1_valid) begin
          g0 = (m_last == 1);
          g1 = !g0;
        end else begin
          g0 = bus.req0_valid;
          g1 = bus.req1_valid;
        end
      end
      iss = m_drain && (occ > 0);

      chk("rnd req0_ready", 32'(bus.req0_ready), 32'(g0));
      chk("rnd req1_ready", 32'(bus.req1_ready), 32'(g1));
      chk("rnd count", 32'(bus.count), 32'(occ));
      chk("rnd full", 32'(bus.full), 32'(occ == DEPTH));
      chk("rnd empty", 32'(bus.empty), 32'(occ == 0));
      chk("rnd load_en", 32'(bus.load_en), 32'(m_pend_v));
      chk("rnd rd_valid", 32'(bus.rd_valid), 32'(m_rv));
      chk("rnd rd_done", 32'(bus.rd_done), 32'(m_done));
      if (m_pend_v) begin
        chk("rnd write_pointer", 32'(bus.write_pointer), 32'(m_pend_a));
        chk("rnd payload", 32'({bus.opcode, bus.operand_a[11:0]}),
            32'({m_pend_w.opc, m_pend_w.op_a[11:0]}));
        chk("rnd operand_b", 32'(bus.operand_b), 32'(m_pend_w.op_b));
      end
      if (iss) chk("rnd read_pointer", 32'(bus.read_pointer), 32'(st_q[0].addr));

      next_cycle();
      m_rv     = iss;
      m_pend_v = g0 | g1;
      if (iss) void'(st_q.pop_front());
      if (g0 | g1) begin
        m_pend_w = g0 ? w0 : w1;
        m_pend_a = address_t'(m_wr_total % DEPTH);
        m_wr_total++;
        st_q.push_back('{w: m_pend_w, addr: m_pend_a});
        m_last = g1 ? 1 : 0;
      end
      done_now = 0;
      if (m_drain) begin
        if (m_all) begin
          if (occ == 0) begin
            m_drain  = 0;
            done_now = 1;
          end
        end else if (iss) begin
          m_rem--;
          if (m_rem == 0) begin
            m_drain  = 0;
            done_now = 1;
          end
        end
      end else if (!m_done && st) begin
        m_drain = 1;
        m_all   = (len == 0);
        m_rem   = int'(len);
      end
      m_done = done_now;
    end
    drive_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_reg_sched.md
# instr_reg_sched

Write/read scheduler for the instruction register file. It arbitrates round-robin between two instruction producers for the single write port and drives load_en, write_pointer and the payload. It also runs a drain FSM that walks read_pointer over stored entries for a downstream consumer. The register file is managed as a DEPTH-entry ring with occupancy tracking; the block sits between producers/consumer and the instruction register.

## Interface
- DEPTH, 32, entries in the register file; power of two, equal to 2**$bits(address_t)
- CNT_W, $clog2(DEPTH)+1, width of occupancy and length fields
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  producer k offers an instruction
- req0_opcode / req1_opcode  input  opcode_t  producer opcode
- req0_operand_a, req0_operand_b / req1_operand_a, req1_operand_b  input  operand_t  producer operands
- req0_ready / req1_ready  output  1  transfer accepted this cycle (valid && ready)
- rd_start  input  1  start drain; sampled only in IDLE
- rd_len  input  CNT_W  entries to drain; 0 = drain until empty
- load_en  output  1  register-file write strobe
- opcode, operand_a, operand_b  output  opcode_t/operand_t  write payload
- write_pointer, read_pointer  output  address_t  register-file addresses
- rd_valid  output  1  instruction_word at read_pointer of previous cycle is valid
- rd_done  output  1  one-cycle pulse at drain completion
- count  output  CNT_W  current occupancy
- full, empty  output  1  count==DEPTH / count==0

## Operation
- Arbitration: when !full, grant goes to the sole valid requester; if both are valid, it goes to the one not granted last. last_grant resets to 1, so req0 wins first. ready_k is combinational from grant and !full. While full, ready is 0 for both requesters and last_grant holds.
- Write: on transfer, the payload and write_pointer are registered. Next cycle load_en=1 for exactly one cycle, then write_pointer increments mod DEPTH (wraps 31->0).
- Drain FSM states: IDLE, DRAIN, DONE.
- IDLE->DRAIN on rd_start; remaining<=rd_len, or <=0 with drain_all flag when rd_len==0.
- In DRAIN, when count>0: issue a read (present read_pointer), increment read_pointer mod DEPTH, decrement count and remaining.
- In DRAIN, when count==0: stall in DRAIN with no read. In drain_all mode, reaching empty ends the drain instead.
- DRAIN->DONE when remaining reaches 0 or (drain_all && count==0). DONE pulses rd_done for one cycle, then returns to IDLE. rd_start outside IDLE is ignored.
- count: +1 on a write transfer, -1 on a read issue, unchanged if both occur in the same cycle. full/empty are derived from the registered count. A transfer into count==0 cannot be read in the same cycle.

## Timing
- Reset values:
  - load_en=0, write_pointer=0, read_pointer=0, count=0, empty=1, full=0
  - rd_valid=0, rd_done=0, state=IDLE
  - payload outputs 0, last_grant=1
- Reset mid-drain or mid-write aborts immediately. No rd_done is issued and the pending load_en is dropped.
- Write latency: transfer in cycle N -> load_en in N+1.
- Read latency: read_pointer presented in cycle N -> rd_valid in N+1. Back-to-back reads give one entry per cycle.
- The earliest rd_start->first read is one cycle (the IDLE->DRAIN transition).

## Configuration
- INSTR_SCHED_STATS_EN defined:
  - adds outputs grant0_cnt, grant1_cnt and stall_cnt, each 16 bits and saturating
  - stall_cnt counts cycles with any valid request while full
  - all three reset to 0
- Undefined: these ports and registers are absent; all other behaviour is identical.

## Structure
- instr_register_pkg owns opcode_t, operand_t, address_t and instruction_t, plus these added items:
  - DEPTH constant
  - sched_state_t enum {IDLE, DRAIN, DONE}
- One sub-module: rr_arb2, the two-requester round-robin arbiter with a hold input driven by full.

## Test plan
- Reset, then drive req0 alone with opcode ADD, a=5, b=3 -> req0_ready=1. Next cycle load_en=1, write_pointer=0, then write_pointer=1 and count=1.
- req0 and req1 valid continuously for 4 cycles -> grants alternate 0,1,0,1 and count=4.
- 32 writes -> full=1 and both ready=0. A 33rd request stalls. A concurrent 1-entry drain frees a slot and the stalled write lands at pointer 0 (wrap).
- 3 entries stored, rd_start with rd_len=0 -> reads at pointers 0,1,2, rd_valid for 3 cycles, rd_done one cycle later, empty=1.
- Empty, rd_start with rd_len=2 -> FSM stalls in DRAIN. Two later writes are read on the cycles after each count increment, then rd_done.
- Assert reset during a 5-entry drain at remaining=2 -> all outputs return to reset values next cycle and no rd_done is issued.
